// File: rtl/adc_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_serial_if
//  Purpose  : Bundles the serial ADC pins and the parallel result port of
//             adc_serial into one interface.
//  Signals  : adc_clk - serial clock to the ADC (idles high)
//             adc_cs  - active-low chip select to the ADC
//             adc_sd  - serial data from the ADC, MSB first
//             data    - last completed conversion result
//             ready   - one-cycle pulse when data has been updated
//  Modports : master - the adc_serial controller
//             slave  - the ADC / result consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface adc_serial_if #(
  parameter int WIDTH = 12
);
  logic             adc_clk;
  logic             adc_cs;
  logic             adc_sd;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (
    output adc_clk,
    output adc_cs,
    input  adc_sd,
    output data,
    output ready
  );

  modport slave (
    input  adc_clk,
    input  adc_cs,
    output adc_sd,
    input  data,
    input  ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_serial.sv
`default_nettype none
// ============================================================================
//  Module   : adc_serial
//  Purpose  : Free-running serial ADC reader. Each frame asserts adc_cs,
//             clocks LEAD_BITS+WIDTH bits out of the ADC, discards the
//             leading bits, publishes the WIDTH-bit result on data with a
//             one-cycle ready pulse, then idles for QUIET_BITS adc_clk
//             periods before starting again.
//  Ports    : clk   - system clock, all logic on its rising edge
//             reset - synchronous, active-high reset
//             bus   - adc_serial_if.master (adc_clk, adc_cs, adc_sd,
//                     data, ready)
//  Params   : WIDTH       - result width in bits (>= 2)
//             LEAD_BITS   - leading bits discarded per frame
//             HALF_PERIOD - clk cycles per adc_clk half-period (>= 1)
//             QUIET_BITS  - adc_clk periods with adc_cs high between
//                           frames (>= 1)
//  Macro    : ADC_SERIAL_TWOS_COMP_EN - when defined, the MSB of the
//             received code is inverted, turning offset binary into
//             two's complement.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_serial #(
  parameter int WIDTH       = 12,
  parameter int LEAD_BITS   = 4,
  parameter int HALF_PERIOD = 2,
  parameter int QUIET_BITS  = 2
) (
  input  logic         clk,
  input  logic         reset,
  adc_serial_if.master bus
);

  localparam int c_n         = LEAD_BITS + WIDTH;
  localparam int c_period    = 2 * HALF_PERIOD;
  localparam int c_quiet_cyc = QUIET_BITS * c_period;
  localparam int c_ph_w      = (c_period > 1)    ? $clog2(c_period)    : 1;
  localparam int c_bit_w     = (c_n > 1)         ? $clog2(c_n)         : 1;
  localparam int c_q_w       = (c_quiet_cyc > 1) ? $clog2(c_quiet_cyc) : 1;

  localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(c_period - 1);
  localparam logic [c_ph_w-1:0]  c_ph_rise  = c_ph_w'(HALF_PERIOD);
  localparam logic [c_ph_w-1:0]  c_ph_one   = c_ph_w'(1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_n - 1);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [c_q_w-1:0]   c_q_last   = c_q_w'(c_quiet_cyc - 1);
  localparam logic [c_q_w-1:0]   c_q_one    = c_q_w'(1);

  typedef enum logic [1:0] {
    START = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_ph_w-1:0]  r_ph;
  logic [c_ph_w-1:0]  w_ph_next;
  logic [c_bit_w-1:0] r_bit;
  logic [c_bit_w-1:0] w_bit_next;
  logic [c_q_w-1:0]   r_q;
  logic [c_q_w-1:0]   w_q_next;

  logic               r_adc_clk;
  logic               r_adc_cs;
  logic               r_ready;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   r_data;

  logic               w_adc_clk_d;
  logic               w_adc_cs_d;
  logic               w_ready_d;
  logic               w_sample;
  logic               w_load;
  logic [WIDTH-1:0]   w_code;

  // The pin registers are loaded from the state the FSM is leaving, so the
  // pins trail the state by one cycle: the START cycle is seen on the pins
  // as cs/clk high, the SHIFT cycles as the 2*HALF_PERIOD adc_clk pattern,
  // and the first QUIET cycle raises cs together with ready and the data
  // load.
  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_bit_next   = r_bit;
    w_q_next     = r_q;
    w_adc_clk_d  = 1'b1;
    w_adc_cs_d   = 1'b1;
    w_ready_d    = 1'b0;
    w_sample     = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      START: begin
        w_state_next = SHIFT;
        w_ph_next    = '0;
        w_bit_next   = '0;
      end

      SHIFT: begin
        w_adc_cs_d  = 1'b0;
        // First half of each period drives adc_clk low, second half high.
        w_adc_clk_d = (r_ph >= c_ph_rise);
        // The edge that drives adc_clk low->high captures adc_sd; the ADC
        // changed it on the preceding falling edge.
        w_sample    = (r_ph == c_ph_rise);
        if (r_ph == c_ph_last) begin
          w_ph_next = '0;
          if (r_bit == c_bit_last) begin
            w_bit_next   = '0;
            w_q_next     = '0;
            w_state_next = QUIET;
          end else begin
            w_bit_next = r_bit + c_bit_one;
          end
        end else begin
          w_ph_next = r_ph + c_ph_one;
        end
      end

      QUIET: begin
        // Leaving the last SHIFT cycle: publish the result exactly once.
        w_ready_d = (r_q == '0);
        w_load    = (r_q == '0);
        if (r_q == c_q_last) begin
          w_q_next     = '0;
          w_state_next = START;
        end else begin
          w_q_next = r_q + c_q_one;
        end
      end

      default: begin
        w_state_next = START;
      end
    endcase
  end

`ifdef ADC_SERIAL_TWOS_COMP_EN
  // Offset binary to two's complement: flip the sign bit only.
  assign w_code = {~r_sr[WIDTH-1], r_sr[WIDTH-2:0]};
`else
  assign w_code = r_sr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= START;
      r_ph      <= '0;
      r_bit     <= '0;
      r_q       <= '0;
      r_adc_clk <= 1'b1;
      r_adc_cs  <= 1'b1;
      r_ready   <= 1'b0;
      r_sr      <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ph      <= w_ph_next;
      r_bit     <= w_bit_next;
      r_q       <= w_q_next;
      r_adc_clk <= w_adc_clk_d;
      r_adc_cs  <= w_adc_cs_d;
      r_ready   <= w_ready_d;
      // Only the last WIDTH samples survive in the register, so the
      // leading bits fall off the top without extra bookkeeping.
      if (w_sample) begin
        r_sr <= {r_sr[WIDTH-2:0], bus.adc_sd};
      end
      if (w_load) begin
        r_data <= w_code;
      end
    end
  end

  assign bus.adc_clk = r_adc_clk;
  assign bus.adc_cs  = r_adc_cs;
  assign bus.ready   = r_ready;
  assign bus.data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_serial
//  Purpose  : Self-checking bench for adc_serial at default parameters. An
//             ADC model shifts out queued 16-bit frames (4 lead bits + 12-bit
//             code) on adc_clk falling edges and pushes the expected result
//             to a scoreboard at each frame start; test tasks pop and compare
//             on every ready pulse.
//  Macro    : ADC_SERIAL_TWOS_COMP_EN - expected codes get their MSB flipped.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_serial;

  localparam int c_frame = 73;
  localparam int c_bound = 200;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;

  adc_serial_if #(.WIDTH(12)) bus ();

  adc_serial #(
    .WIDTH       (12),
    .LEAD_BITS   (4),
    .HALF_PERIOD (2),
    .QUIET_BITS  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  logic [15:0] adc_q[$];
  logic [11:0] exp_q[$];

  function automatic logic [11:0] expect_of(input logic [11:0] code);
`ifdef ADC_SERIAL_TWOS_COMP_EN
    return {~code[11], code[10:0]};
`else
    return code;
`endif
  endfunction

  // ADC model: new frame on adc_cs falling, next bit after each adc_clk fall.
  logic [15:0] cur_word;
  int          bit_idx;
  bit          in_frame;
  logic        prev_aclk;

  always @(negedge clk) begin
    if (bus.adc_cs !== 1'b0) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        in_frame = 1'b1;
        bit_idx  = 0;
        if (adc_q.size() > 0) cur_word = adc_q.pop_front();
        else                  cur_word = 16'h0000;
        exp_q.push_back(expect_of(cur_word[11:0]));
      end
      if (prev_aclk === 1'b1 && bus.adc_clk === 1'b0 && bit_idx < 16) begin
        bus.adc_sd = cur_word[15-bit_idx];
        bit_idx++;
      end
    end
    prev_aclk = bus.adc_clk;
  end

  // Protocol monitor, enabled only during reset-free windows.
  bit   chk_en;
  int   viol_clk;
  int   viol_rdy;
  logic mon_prev_cs;
  logic mon_prev_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.adc_cs === 1'b1 && bus.adc_clk !== 1'b1) viol_clk++;
      if (bus.ready === 1'b1 && !(mon_prev_cs === 1'b0 && bus.adc_cs === 1'b1)) viol_rdy++;
      if (mon_prev_cs === 1'b0 && bus.adc_cs === 1'b1 && bus.ready !== 1'b1) viol_rdy++;
      if (bus.ready === 1'b1 && mon_prev_rdy === 1'b1) viol_rdy++;
    end
    mon_prev_cs  = bus.adc_cs;
    mon_prev_rdy = bus.ready;
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < c_bound; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Park in a cs-high gap so new frames line up with the scoreboard.
  task automatic sync_quiet();
    for (int i = 0; i < c_bound; i++) begin
      @(negedge clk);
      if (bus.adc_cs === 1'b1) break;
    end
    adc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit          ok;
    int          c0;
    int          low_cnt;
    logic [11:0] e;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.adc_cs !== 1'b1)  begin failures++; $display("FAIL rst_cs: got %b want 1", bus.adc_cs); end
    checks++; if (bus.adc_clk !== 1'b1) begin failures++; $display("FAIL rst_aclk: got %b want 1", bus.adc_clk); end
    checks++; if (bus.data !== 12'h000) begin failures++; $display("FAIL rst_data: got %h want 000", bus.data); end
    checks++; if (bus.ready !== 1'b0)   begin failures++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    adc_q.delete();
    exp_q.delete();
    adc_q.push_back({4'h0, 12'hA5C});
    reset   = 1'b0;
    c0      = cyc;
    low_cnt = 0;
    ok      = 1'b0;
    for (int i = 0; i < c_bound; i++) begin
      @(negedge clk);
      if (bus.adc_cs === 1'b0) low_cnt++;
      if (bus.ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL first_ready: got ready=0 want ready=1 within %0d cycles", c_bound);
    end else begin
      checks++; if (cyc - c0 !== 66) begin failures++; $display("FAIL first_latency: got %0d want 66 edges", cyc - c0); end
      checks++; if (low_cnt !== 64)  begin failures++; $display("FAIL cs_low_len: got %0d want 64", low_cnt); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      checks++; if (bus.data !== e)  begin failures++; $display("FAIL a5c_data: got %h want %h", bus.data, e); end
    end
  endtask

  task automatic test_lead_bits();
    bit          ok;
    logic [11:0] e;
    sync_quiet();
    adc_q.push_back({4'hF, 12'h123});
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL lead_ready: got ready=0 want ready=1");
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      checks++; if (bus.data !== e) begin failures++; $display("FAIL lead_data: got %h want %h", bus.data, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    int          t[2];
    logic [11:0] e;
    sync_quiet();
    adc_q.push_back({4'h0, 12'hFFF});
    adc_q.push_back({4'h0, 12'h000});
    for (int k = 0; k < 2; k++) begin
      wait_ready(ok);
      t[k] = cyc;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL b2b_ready%0d: got ready=0 want ready=1", k);
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        checks++; if (bus.data !== e) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", k, bus.data, e); end
      end
    end
    checks++;
    if (t[1] - t[0] !== c_frame) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], c_frame); end
  endtask

  task automatic test_twos_comp();
    bit          ok;
    logic [11:0] e;
    sync_quiet();
    adc_q.push_back({4'h0, 12'h800});
    adc_q.push_back({4'h0, 12'h7FF});
    for (int k = 0; k < 2; k++) begin
      wait_ready(ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL tc_ready%0d: got ready=0 want ready=1", k);
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        checks++; if (bus.data !== e) begin failures++; $display("FAIL tc_data%0d: got %h want %h", k, bus.data, e); end
      end
    end
  endtask

  task automatic test_patterns();
    bit          ok;
    logic [11:0] e;
    sync_quiet();
    for (int k = 0; k < 4; k++) adc_q.push_back(16'($urandom));
    for (int k = 0; k < 4; k++) begin
      wait_ready(ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL pat_ready%0d: got ready=0 want ready=1", k);
      end else begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        checks++; if (bus.data !== e) begin failures++; $display("FAIL pat_data%0d: got %h want %h", k, bus.data, e); end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit          ok;
    bit          started;
    bit          rdy_seen;
    logic        pcs;
    logic [11:0] e;
    started = 1'b0;
    pcs     = bus.adc_cs;
    for (int i = 0; i < c_bound; i++) begin
      @(negedge clk);
      if (pcs === 1'b1 && bus.adc_cs === 1'b0) begin
        started = 1'b1;
        break;
      end
      pcs = bus.adc_cs;
    end
    checks++;
    if (!started) begin failures++; $display("FAIL mr_frame_start: got cs_fall=0 want 1"); end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.adc_cs !== 1'b1)  begin failures++; $display("FAIL mr_cs: got %b want 1", bus.adc_cs); end
    checks++; if (bus.adc_clk !== 1'b1) begin failures++; $display("FAIL mr_aclk: got %b want 1", bus.adc_clk); end
    checks++; if (bus.data !== 12'h000) begin failures++; $display("FAIL mr_data: got %h want 000", bus.data); end
    rdy_seen = (bus.ready === 1'b1);
    repeat (3) begin
      @(negedge clk);
      if (bus.ready === 1'b1) rdy_seen = 1'b1;
    end
    checks++; if (rdy_seen) begin failures++; $display("FAIL mr_ready: got ready=1 want 0 during reset"); end
    adc_q.delete();
    exp_q.delete();
    adc_q.push_back({4'h0, 12'h3C7});
    reset = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mr_restart_ready: got ready=0 want ready=1");
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      checks++; if (bus.data !== e) begin failures++; $display("FAIL mr_restart_data: got %h want %h", bus.data, e); end
    end
  endtask

  task automatic test_invariants();
    bit          ok;
    bit          all_ok;
    int          t_first;
    int          t_last;
    int          bad_data;
    logic [11:0] e;
    sync_quiet();
    for (int k = 0; k < 100; k++) adc_q.push_back(16'($urandom));
    viol_clk = 0;
    viol_rdy = 0;
    bad_data = 0;
    all_ok   = 1'b1;
    t_first  = 0;
    t_last   = 0;
    chk_en   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wait_ready(ok);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
      if (k == 0) t_first = cyc;
      t_last = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      if (bus.data !== e) bad_data++;
    end
    chk_en = 1'b0;
    checks++; if (!all_ok)       begin failures++; $display("FAIL inv_ready: got ready=0 want ready=1 each frame"); end
    checks++; if (viol_clk !== 0) begin failures++; $display("FAIL inv_aclk_idle: got %0d violations want 0", viol_clk); end
    checks++; if (viol_rdy !== 0) begin failures++; $display("FAIL inv_ready_pulse: got %0d violations want 0", viol_rdy); end
    checks++; if (bad_data !== 0) begin failures++; $display("FAIL inv_data: got %0d bad frames want 0", bad_data); end
    checks++;
    if (t_last - t_first !== 99 * c_frame) begin
      failures++; $display("FAIL inv_period: got %0d want %0d", t_last - t_first, 99 * c_frame);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    chk_en     = 1'b0;
    in_frame   = 1'b0;
    bit_idx    = 0;
    cur_word   = 16'h0000;
    prev_aclk  = 1'b1;
    bus.adc_sd = 1'b0;
    reset      = 1'b1;
    test_reset();
    test_lead_bits();
    test_back_to_back();
    test_twos_comp();
    test_patterns();
    test_mid_reset();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_serial.md
ADC_SERIAL -- requirements
Module: adc_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 12, as the conversion result width in bits.
REQ-002 SHALL have parameter LEAD_BITS, default 4, as the number of leading zero bits per frame, which are discarded.
REQ-003 SHALL have parameter HALF_PERIOD, default 2, as the number of clk cycles per adc_clk half-period (adc_clk = clk/4 at default).
REQ-004 SHALL have parameter QUIET_BITS, default 2, as the number of adc_clk periods that adc_cs stays high between frames.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port adc_clk, output, 1 bit: serial clock to the ADC, registered.
REQ-008 SHALL have port adc_cs, output, 1 bit: active-low chip select, registered.
REQ-009 SHALL have port adc_sd, input, 1 bit: serial data from the ADC, MSB first, which the ADC changes on adc_clk falling edges.
REQ-010 SHALL have port data, output, WIDTH bits: the last completed conversion result.
REQ-011 SHALL have port ready, output, 1 bit: one-clk-cycle pulse marking that data has been updated.

Function
REQ-012 SHALL implement three states: START, SHIFT and QUIET.
REQ-013 START SHALL last 1 clk cycle, in which adc_cs is driven low and adc_clk stays high; the block SHALL then enter SHIFT.
REQ-014 SHIFT SHALL generate N = LEAD_BITS+WIDTH adc_clk periods; each period SHALL be HALF_PERIOD clk cycles with adc_clk low, followed by HALF_PERIOD clk cycles with adc_clk high.
REQ-015 adc_sd SHALL be sampled into a shift register on the clk edge that drives adc_clk from low to high.
REQ-016 The first LEAD_BITS samples SHALL be discarded; the following WIDTH samples SHALL form the result, MSB first.
REQ-017 On the clk edge that ends the Nth high phase, the block SHALL simultaneously drive adc_cs high, load data and assert ready.
REQ-018 ready SHALL be high for exactly one clk cycle per frame and SHALL never be high at any other time.
REQ-019 data SHALL hold its value between ready pulses and SHALL be unchanged by an incomplete frame.
REQ-020 QUIET SHALL hold adc_cs high and adc_clk high for QUIET_BITS*2*HALF_PERIOD clk cycles, then return to START.
REQ-021 The frame period SHALL be 1 + (N+QUIET_BITS)*2*HALF_PERIOD clk cycles, which is 73 at defaults; the block SHALL free-run with no handshake.
REQ-022 adc_clk SHALL idle high whenever adc_cs is high.
REQ-023 Counters SHALL be sized from the parameters; wrap-around SHALL occur only at the state transitions defined above.

Reset
REQ-024 While reset is high: adc_cs=1, adc_clk=1, data=0, ready=0, the shift register is cleared, and the state is START pending release.
REQ-025 Reset asserted mid-frame SHALL abort the frame at the next clk edge, producing no ready pulse and leaving data=0.
REQ-026 The first START SHALL occur on the first clk edge after reset is sampled low; at defaults, the first ready SHALL follow 65 clk cycles later.

Configuration
REQ-027 Macro ADC_SERIAL_TWOS_COMP_EN SHALL control the output coding.
REQ-028 When ADC_SERIAL_TWOS_COMP_EN is defined, the MSB of the received code SHALL be inverted before loading data, converting offset binary to two's complement (0x800 becomes 0x000, 0x000 becomes 0x800).
REQ-029 When ADC_SERIAL_TWOS_COMP_EN is not defined, data SHALL equal the received code unmodified.

Verification
REQ-030 The ADC model sends 0000 followed by 0xA5C -> data=0xA5C with one ready pulse; adc_cs is low for exactly 64 clk cycles.
REQ-031 The ADC model sends 0xFFF, then 0x000 on consecutive frames -> data=0xFFF then 0x000; ready pulses are 73 clk cycles apart.
REQ-032 Non-zero lead bits (1111) followed by 0x123 -> data=0x123, showing the lead bits are ignored.
REQ-033 Reset asserted 30 cycles into a frame -> adc_cs=1, adc_clk=1, data=0 and no ready on the next edge; a clean frame restarts after release.
REQ-034 With ADC_SERIAL_TWOS_COMP_EN defined and the ADC model sending 0x800, then 0x7FF -> data=0x000, then 0xFFF.
REQ-035 A checker SHALL confirm, over 100 frames, that adc_clk is high whenever adc_cs is high and that ready is high for 1 cycle per frame.
